// File: rtl/timer_ctrl_if.sv
// Command bus between a host/register block and timer_ctrl.
// The host drives op/data/mode with a valid strobe; the timer answers with ready.
interface timer_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             cfg_periodic;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output cfg_periodic,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  cfg_periodic,
        output cmd_ready
    );
endinterface

// File: rtl/timer_ctrl.sv
// Command-driven programmable timer: sequences a WIDTH-bit counter through
// IDLE/RUN/PAUSE/DONE with one-shot or periodic terminal-count behaviour.
module timer_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    timer_ctrl_if.slave      cmd,
    output logic [WIDTH-1:0] out,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] wrap_cnt,
    output logic             err
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_PAUSE = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic [WIDTH-1:0] limit_reg, limit_next;
    logic             periodic_reg, periodic_next;
    logic [WIDTH-1:0] wrap_reg, wrap_next;
    logic             err_reg, err_next;

    logic             at_limit;

    assign at_limit = (out_reg == limit_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            out_reg      <= '0;
            limit_reg    <= ALL_ONES;
            periodic_reg <= 1'b0;
            wrap_reg     <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            out_reg      <= out_next;
            limit_reg    <= limit_next;
            periodic_reg <= periodic_next;
            wrap_reg     <= wrap_next;
            err_reg      <= err_next;
        end
    end

    // An accepted command always wins over the terminal-count action, and an
    // illegal one leaves every register untouched apart from the err pulse.
    always_comb begin
        state_next    = state_reg;
        out_next      = out_reg;
        limit_next    = limit_reg;
        periodic_next = periodic_reg;
        wrap_next     = wrap_reg;
        err_next      = 1'b0;

        if (cmd.cmd_valid) begin
            unique case (cmd.cmd_op)
                OP_START: begin
                    if (state_reg == ST_PAUSE) begin
                        err_next = 1'b1;
                    end else begin
                        state_next    = ST_RUN;
                        out_next      = '0;
                        wrap_next     = '0;
                        periodic_next = cmd.cfg_periodic;
                    end
                end
                OP_STOP: begin
                    state_next = ST_IDLE;
                    out_next   = '0;
                end
                OP_PAUSE: begin
                    if (state_reg == ST_RUN) begin
                        state_next = ST_PAUSE;
                    end else if (state_reg == ST_PAUSE) begin
                        state_next = ST_RUN;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                OP_LOAD: begin
                    if (state_reg == ST_IDLE || state_reg == ST_DONE) begin
                        limit_next = cmd.cmd_data;
                        state_next = ST_IDLE;
                        out_next   = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                default: begin
                    err_next = 1'b1;
                end
            endcase
        end else if (state_reg == ST_RUN) begin
            if (!at_limit) begin
                out_next = out_reg + 1'b1;
            end else if (periodic_reg) begin
                out_next = '0;
                if (wrap_reg != ALL_ONES) begin
                    wrap_next = wrap_reg + 1'b1;
                end
            end else begin
                state_next = ST_DONE;
            end
        end
    end

    // All status outputs decode registered state only.
    assign cmd.cmd_ready = 1'b1;
    assign out           = out_reg;
    assign wrap_cnt      = wrap_reg;
    assign err           = err_reg;
    assign tick          = (state_reg == ST_RUN) && at_limit;
    assign busy          = (state_reg == ST_RUN) || (state_reg == ST_PAUSE);
    assign done          = (state_reg == ST_DONE);
endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Command-driven controller that sequences an internal WIDTH-bit free-running counter as a programmable timer. It accepts START/STOP/PAUSE/LOAD commands over a valid/ready port and supports one-shot or periodic terminal-count behaviour. It reports terminal-count ticks and a saturating wrap count. It sits between a host/register interface and the counter datapath, replacing direct reset-based control of the counter.

## Interface
- WIDTH, 8, width of count value, limit and wrap count
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready; constant 1 (every command accepted in one cycle)
- cmd_op  in  2  00 START, 01 STOP, 10 PAUSE (toggle pause/resume), 11 LOAD
- cmd_data  in  WIDTH  LOAD operand (new limit); ignored for other ops
- cfg_periodic  in  1  mode, sampled only when START is accepted: 1 periodic, 0 one-shot
- out  out  WIDTH  current count value
- tick  out  1  high while state==RUN && out==limit
- busy  out  1  state is RUN or PAUSE
- done  out  1  state is DONE
- wrap_cnt  out  WIDTH  number of periodic wraps since last START; saturates at all-ones
- err  out  1  one-cycle registered pulse, cycle after an illegal command was accepted

## Operation
- States: IDLE, RUN, PAUSE, DONE. Registers: state, out, limit, periodic, wrap_cnt, err.
- Command handling (accepted command has priority over terminal-count action in the same cycle):
  - START: in IDLE/DONE/RUN -> RUN, out<=0, wrap_cnt<=0, periodic<=cfg_periodic (RUN = restart). In PAUSE -> illegal.
  - STOP: any state -> IDLE, out<=0. wrap_cnt and limit hold.
  - PAUSE: RUN -> PAUSE (out holds); PAUSE -> RUN (resume from held out). In IDLE/DONE -> illegal.
  - LOAD: in IDLE/DONE -> limit<=cmd_data, state->IDLE, out<=0. In RUN/PAUSE -> illegal.
  - Illegal command: no state/register change except err<=1 for one cycle.
- RUN without command: if out!=limit, out<=out+1. If out==limit:
  - periodic: out<=0; wrap_cnt<=wrap_cnt+1, unless already all-ones.
  - one-shot: state->DONE; out holds limit.
- PAUSE/IDLE/DONE without command: all registers hold.
- Arithmetic: out never exceeds limit, so it never wraps modulo 2^WIDTH. limit=0: periodic ticks every cycle; one-shot reaches DONE one cycle after START.
- tick, busy and done are decoded from registered state only; no combinational path from cmd_* to any output.

## Timing
- Reset values: state IDLE, out 0, limit all-ones (8'hFF), periodic 0, wrap_cnt 0, err 0. Outputs: tick 0, busy 0, done 0, cmd_ready 1.
- Reset asserted mid-RUN or mid-PAUSE: next edge gives the reset values above; any command in that cycle is discarded.
- START accepted at edge k gives out=0 after edge k and out=n after edge k+n.
- tick is high during the cycle after edge k+L, where L=limit.
- One-shot: done=1 after edge k+L+1.
- Periodic: out=0 after edge k+L+1; period is L+1 cycles; wrap_cnt increments at each edge where out returns to 0.
- PAUSE accepted at edge p freezes out at its value after p. Resume at edge r: counting continues at edge r+1.
- STOP in the same cycle as tick: tick is still high that cycle. After the edge: IDLE, out=0, no wrap_cnt increment.
- err rises the cycle after the illegal command's edge and lasts exactly one cycle; back-to-back illegal commands give err high continuously.

## Test plan
- Reset: hold rst 2 cycles -> out=0, limit=FF, busy=0, done=0, tick=0, err=0, cmd_ready=1.
- LOAD 5, then START with cfg_periodic=0 -> out counts 0..5; tick high one cycle at out=5; next cycle done=1, out=5; stays there for 20 cycles.
- LOAD 3, then START periodic; run 16 cycles -> out sequence 0,1,2,3,0,1,...; tick every 4th cycle; wrap_cnt=4. Also with limit=0 -> tick constant 1 and wrap_cnt saturating at FF after 255 wraps.
- Run limit=10, PAUSE at out=4 and hold 7 cycles -> out stays 4, busy=1. PAUSE again (resume) -> next value 5; tick at out=10.
- Illegal commands: LOAD during RUN, START during PAUSE, PAUSE in IDLE -> each gives exactly one err pulse; limit, out and state unchanged.
- Simultaneous events and reset:
  - STOP on the tick cycle -> IDLE, out=0, wrap_cnt unchanged.
  - START on the tick cycle (periodic) -> out=0 and wrap_cnt=0 after the edge.
  - rst mid-RUN at out=7 -> out=0 and IDLE after the edge.
